// File: rtl/dispatch_pkg.sv
// Shared widths and instruction type tags for the dispatch unit.
// Combinational definitions only; no latency or backpressure of its own.
package dispatch_pkg;
  localparam int DEF_INST_W = 78;
  localparam int DEF_DATA_W = DEF_INST_W - 2;

  localparam logic [1:0] TAG_BUBBLE  = 2'b00;
  localparam logic [1:0] TAG_COMPLEX = 2'b01;
  localparam logic [1:0] TAG_FP      = 2'b10;
  localparam logic [1:0] TAG_SIMPLE  = 2'b11;
endpackage

// File: rtl/dispatch_slot_pick.sv
// Two-request priority picker over an ordered candidate list; A picks first, B takes the next free slot.
// Combinational (0 cycles); a request with no free candidate raises its full flag instead of a grant.
module dispatch_slot_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] avail_i,
  input  logic [N-1:0] excl_b_i,
  input  logic         req_a_i,
  input  logic         req_b_i,
  output logic [N-1:0] grant_a_o,
  output logic [N-1:0] grant_b_o,
  output logic         full_a_o,
  output logic         full_b_o
);
  logic [N-1:0] rem_b;
  logic         found_a;
  logic         found_b;

  // excl_b_i masks slots that A was granted through another class's picker
  always_comb begin
    grant_a_o = '0;
    grant_b_o = '0;
    found_a   = 1'b0;
    found_b   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_a_i && avail_i[i] && !found_a) begin
        grant_a_o[i] = 1'b1;
        found_a      = 1'b1;
      end
    end
    rem_b = avail_i & ~grant_a_o & ~excl_b_i;
    for (int i = 0; i < N; i++) begin
      if (req_b_i && rem_b[i] && !found_b) begin
        grant_b_o[i] = 1'b1;
        found_b      = 1'b1;
      end
    end
    full_a_o = req_a_i && !found_a;
    full_b_o = req_b_i && !found_b;
  end
endmodule

// File: rtl/dispatch_unit.sv
// Dispatches two in-order decoded instructions into complex/simple/fp reservation-station entries.
// 1-cycle registered latency; stalls via rs_full_A/B, B never passes a stalled A. Option: DISPATCH_SIMPLE_TO_COMPLEX_EN.
module dispatch_unit
  import dispatch_pkg::*;
#(
  parameter int INST_W = DEF_INST_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INST_W-1:0] instA,
  input  logic [INST_W-1:0] instB,
  input  logic              complex_empty_0,
  input  logic              complex_empty_1,
  input  logic              simple_empty_0,
  input  logic              simple_empty_1,
  input  logic              fp_empty_0,
  input  logic              fp_empty_1,
  output logic [DATA_W-1:0] complex_0_data,
  output logic [DATA_W-1:0] complex_1_data,
  output logic [DATA_W-1:0] simple_0_data,
  output logic [DATA_W-1:0] simple_1_data,
  output logic [DATA_W-1:0] fp_0_data,
  output logic [DATA_W-1:0] fp_1_data,
  output logic              complex_0_valid,
  output logic              complex_1_valid,
  output logic              simple_0_valid,
  output logic              simple_1_valid,
  output logic              fp_0_valid,
  output logic              fp_1_valid,
  output logic              rs_full_A,
  output logic              rs_full_B
);
  logic [1:0]        tag_a, tag_b;
  logic [DATA_W-1:0] pay_a, pay_b;
  logic [1:0]        cx_ga, cx_gb, fp_ga, fp_gb;
  logic [3:0]        sp_ga, sp_gb, sp_avail;
  logic              cx_fa, cx_fb, sp_fa, sp_fb, fp_fa, fp_fb;
  logic              full_a, b_go;

  assign tag_a = instA[1:0];
  assign tag_b = instB[1:0];
  assign pay_a = instA[INST_W-1:2];
  assign pay_b = instB[INST_W-1:2];

  assign full_a = cx_fa | sp_fa | fp_fa;
  assign b_go   = ~full_a;

`ifdef DISPATCH_SIMPLE_TO_COMPLEX_EN
  assign sp_avail = {complex_empty_1, complex_empty_0, simple_empty_1, simple_empty_0};
`else
  assign sp_avail = {2'b00, simple_empty_1, simple_empty_0};
`endif

  // complex entries are shared with simple overflow, so each picker hides A's grant from the other
  dispatch_slot_pick #(.N(2)) u_pick_cx (
    .avail_i  ({complex_empty_1, complex_empty_0}),
    .excl_b_i (sp_ga[3:2]),
    .req_a_i  (tag_a == TAG_COMPLEX),
    .req_b_i  ((tag_b == TAG_COMPLEX) && b_go),
    .grant_a_o(cx_ga),
    .grant_b_o(cx_gb),
    .full_a_o (cx_fa),
    .full_b_o (cx_fb)
  );

  dispatch_slot_pick #(.N(4)) u_pick_sp (
    .avail_i  (sp_avail),
    .excl_b_i ({cx_ga, 2'b00}),
    .req_a_i  (tag_a == TAG_SIMPLE),
    .req_b_i  ((tag_b == TAG_SIMPLE) && b_go),
    .grant_a_o(sp_ga),
    .grant_b_o(sp_gb),
    .full_a_o (sp_fa),
    .full_b_o (sp_fb)
  );

  dispatch_slot_pick #(.N(2)) u_pick_fp (
    .avail_i  ({fp_empty_1, fp_empty_0}),
    .excl_b_i (2'b00),
    .req_a_i  (tag_a == TAG_FP),
    .req_b_i  ((tag_b == TAG_FP) && b_go),
    .grant_a_o(fp_ga),
    .grant_b_o(fp_gb),
    .full_a_o (fp_fa),
    .full_b_o (fp_fb)
  );

  // entry order: complex_0, complex_1, simple_0, simple_1, fp_0, fp_1
  logic [5:0]             hit_a, hit_b, vld_d, vld_q;
  logic [5:0][DATA_W-1:0] dat_d, dat_q;
  logic                   full_a_q, full_b_d, full_b_q;

  assign hit_a = {fp_ga, sp_ga[1:0], cx_ga | sp_ga[3:2]};
  assign hit_b = {fp_gb, sp_gb[1:0], cx_gb | sp_gb[3:2]};

  always_comb begin
    vld_d = hit_a | hit_b;
    dat_d = '0;
    for (int i = 0; i < 6; i++) begin
      if (hit_a[i]) dat_d[i] = pay_a;
      else if (hit_b[i]) dat_d[i] = pay_b;
    end
  end

  assign full_b_d = (tag_b != TAG_BUBBLE) && (full_a || cx_fb || sp_fb || fp_fb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      dat_q    <= '0;
      full_a_q <= 1'b0;
      full_b_q <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      dat_q    <= dat_d;
      full_a_q <= full_a;
      full_b_q <= full_b_d;
    end
  end

  assign complex_0_data  = dat_q[0];
  assign complex_1_data  = dat_q[1];
  assign simple_0_data   = dat_q[2];
  assign simple_1_data   = dat_q[3];
  assign fp_0_data       = dat_q[4];
  assign fp_1_data       = dat_q[5];
  assign complex_0_valid = vld_q[0];
  assign complex_1_valid = vld_q[1];
  assign simple_0_valid  = vld_q[2];
  assign simple_1_valid  = vld_q[3];
  assign fp_0_valid      = vld_q[4];
  assign fp_1_valid      = vld_q[5];
  assign rs_full_A       = full_a_q;
  assign rs_full_B       = full_b_q;
endmodule

// File: tb/tb_dispatch_unit.sv
// Scoreboarded random + directed bench for dispatch_unit against a candidate-list reference model.
module tb_dispatch_unit;
  import dispatch_pkg::*;
  localparam int IW = 78;
  localparam int DW = 76;

  logic clk = 1'b0;
  logic rst_n;
  logic [IW-1:0] instA, instB;
  logic [5:0] emp;
  logic [DW-1:0] c0d, c1d, s0d, s1d, f0d, f1d;
  logic c0v, c1v, s0v, s1v, f0v, f1v, full_a, full_b;

  always #5 clk = ~clk;

  dispatch_unit dut (
    .clk(clk), .rst_n(rst_n), .instA(instA), .instB(instB),
    .complex_empty_0(emp[0]), .complex_empty_1(emp[1]),
    .simple_empty_0(emp[2]), .simple_empty_1(emp[3]),
    .fp_empty_0(emp[4]), .fp_empty_1(emp[5]),
    .complex_0_data(c0d), .complex_1_data(c1d), .simple_0_data(s0d),
    .simple_1_data(s1d), .fp_0_data(f0d), .fp_1_data(f1d),
    .complex_0_valid(c0v), .complex_1_valid(c1v), .simple_0_valid(s0v),
    .simple_1_valid(s1v), .fp_0_valid(f0v), .fp_1_valid(f1v),
    .rs_full_A(full_a), .rs_full_B(full_b)
  );

  logic [5:0]         got_v;
  logic [5:0][DW-1:0] got_d;
  assign got_v = {f1v, f0v, s1v, s0v, c1v, c0v};
  assign got_d = {f1d, f0d, s1d, s0d, c1d, c0d};

  typedef struct packed {
    logic [5:0]         v;
    logic [5:0][DW-1:0] d;
    logic               fa;
    logic               fb;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Candidate entries (index into the empty vector) in priority order, -1 = none.
  function automatic int pick(input logic [1:0] tag, input logic [5:0] avail);
    int cand[4];
    case (tag)
      2'b01:   cand = '{0, 1, -1, -1};
`ifdef DISPATCH_SIMPLE_TO_COMPLEX_EN
      2'b11:   cand = '{2, 3, 0, 1};
`else
      2'b11:   cand = '{2, 3, -1, -1};
`endif
      2'b10:   cand = '{4, 5, -1, -1};
      default: cand = '{-1, -1, -1, -1};
    endcase
    for (int k = 0; k < 4; k++)
      if (cand[k] >= 0 && avail[cand[k]]) return cand[k];
    return -1;
  endfunction

  function automatic exp_t model(input logic [IW-1:0] a, input logic [IW-1:0] b,
                                 input logic [5:0] empty);
    exp_t e;
    logic [5:0] avail;
    int ia, ib;
    e = '0;
    avail = empty;
    if (a[1:0] != 2'b00) begin
      ia = pick(a[1:0], avail);
      if (ia < 0) e.fa = 1'b1;
      else begin
        e.v[ia] = 1'b1; e.d[ia] = a[IW-1:2]; avail[ia] = 1'b0;
      end
    end
    if (b[1:0] != 2'b00) begin
      if (e.fa) e.fb = 1'b1;
      else begin
        ib = pick(b[1:0], avail);
        if (ib < 0) e.fb = 1'b1;
        else begin
          e.v[ib] = 1'b1; e.d[ib] = b[IW-1:2];
        end
      end
    end
    return e;
  endfunction

  task automatic apply(input logic [1:0] ta, input logic [DW-1:0] pa,
                       input logic [1:0] tb, input logic [DW-1:0] pb, input logic [5:0] e);
    @(negedge clk);
    instA = {pa, ta};
    instB = {pb, tb};
    emp   = e;
    exp_q.push_back(model(instA, instB, emp));
  endtask

  function automatic logic [DW-1:0] rand_pay();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // Monitor: outputs registered at edge N are compared just after that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (got_v !== e.v) begin
          errors++;
          $display("FAIL valids: got %b expected %b", got_v, e.v);
        end
        checks++;
        if (got_d !== e.d) begin
          errors++;
          $display("FAIL data: got %h expected %h", got_d, e.d);
        end
        checks++;
        if ({full_a, full_b} !== {e.fa, e.fb}) begin
          errors++;
          $display("FAIL rs_full: got A=%b B=%b expected A=%b B=%b", full_a, full_b, e.fa, e.fb);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if (got_v !== 6'b0 || got_d !== '0 || full_a !== 1'b0 || full_b !== 1'b0) begin
      errors++;
      $display("FAIL %s: got v=%b fa=%b fb=%b data=%h expected all zero",
               name, got_v, full_a, full_b, got_d);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    instA = '0;
    instB = '0;
    emp   = '0;
    #2;
    check_zero("reset_state");
    #10 rst_n = 1'b1;

    apply(TAG_SIMPLE, 76'd2021, TAG_SIMPLE, 76'd30, 6'b111111);
    apply(TAG_BUBBLE, 76'd2021, TAG_BUBBLE, 76'd2030, 6'b111111);
    apply(TAG_SIMPLE, 76'd2021, TAG_SIMPLE, 76'd2030, 6'b110011);
    apply(TAG_SIMPLE, 76'd1111, TAG_SIMPLE, 76'd99, 6'b000010);
    apply(TAG_FP, 76'd34, TAG_FP, 76'd24, 6'b011111);
    apply(TAG_SIMPLE, 76'd44, TAG_BUBBLE, 76'd14, 6'b111111);
    apply(TAG_COMPLEX, 76'd5, TAG_SIMPLE, 76'd6, 6'b000011);
    apply(TAG_SIMPLE, 76'd7, TAG_COMPLEX, 76'd8, 6'b000001);
    apply(TAG_FP, 76'd9, TAG_COMPLEX, 76'd10, 6'b001111);
    apply(TAG_BUBBLE, 76'd11, TAG_FP, 76'd12, 6'b100000);

    for (int i = 0; i < 400; i++)
      apply(2'($urandom_range(0, 3)), rand_pay(), 2'($urandom_range(0, 3)), rand_pay(),
            6'($urandom));

    apply(TAG_COMPLEX, 76'd321, TAG_COMPLEX, 76'd654, 6'b111111);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    // Outputs from the last complex pair are held; reset must clear them without a clock edge.
    checks++;
    if ({c1v, c0v} !== 2'b11) begin
      errors++;
      $display("FAIL complex_pair_before_reset: got %b expected 11", {c1v, c0v});
    end
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
